fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline: owns the PC, issues requests to a req/gnt/rvalid instruction memory,
//  and drives the IF/ID pipeline register consumed by decode (regfile/extend/controller).
//  Absorbs decode stalls with a 1-entry skid buffer; handles branch/jump redirects from EX with flush.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  XLEN      32             address/data width
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  id_stall       in   1     decode cannot accept; hold IF/ID contents
//  redirect       in   1     EX-resolved taken branch/jump (PCSrc)
//  redirect_pc    in   32    target (PCTarget); bits[1:0] forced to 0
//  imem_req_o     out  1     request valid
//  imem_addr_o    out  32    request address
//  imem_gnt_i     in   1     request accepted this cycle
//  imem_rvalid_i  in   1     response data valid
//  imem_rdata_i   in   32    instruction word
//  ifid_valid_o   out  1     IF/ID holds a live instruction
//  ifid_instr_o   out  32    instruction
//  ifid_pc_o      out  32    its PC
//  ifid_pcplus4_o out  32    its PC+4
// BEHAVIOUR
//  Reset: pc=RESET_PC, outstanding=0, kill=0, skid empty, ifid_valid_o=0, ifid_instr_o=NOP (32'h0000_0013),
//   ifid_pc_o=0, ifid_pcplus4_o=0, imem_req_o=0. Reset mid-transaction discards any in-flight response.
//  Outstanding FSM, two states: IDLE (none in flight) / WAIT (one in flight); never more than one.
//  imem_req_o = !redirect && !skid_full && (IDLE || imem_rvalid_i); imem_addr_o = pc.
//   req&&gnt: pc<=pc+4 (mod 2^32 wrap), state->WAIT. rvalid without new gnt: WAIT->IDLE.
//  Response routing (rvalid && !kill): if IF/ID empty or (!id_stall && skid empty) -> load IF/ID;
//   else -> skid. When !id_stall and skid full, IF/ID loads from skid first (program order kept);
//   a same-cycle response then goes to skid. Response with kill=1 is dropped; kill cleared.
//  id_stall=1: IF/ID outputs hold; at most one further word buffered; req suppressed while skid full.
//  redirect=1 (wins over id_stall and over rvalid): ifid_valid_o<=0, ifid_instr_o<=NOP, skid cleared,
//   pc<=redirect_pc&~3; kill<=1 if a request is outstanding and its rvalid is not in this cycle.
//  Latency (gnt=1, rvalid 1 cycle after gnt): redirect in cycle N -> req to target in N+1 ->
//   target valid on IF/ID in N+3. Steady state: 1 instruction/cycle, no bubbles.
//  ifid_pcplus4_o = ifid_pc_o + 4, registered with the instruction.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched_o[31:0] (responses delivered to IF/ID or skid) and
//   perf_killed_o[31:0] (responses dropped by kill + valid entries flushed); reset 0, wrap at 2^32.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  rv32_pkg: XLEN, RV_NOP=32'h0000_0013, fetch_state_e {IDLE,WAIT}, typedef ifid_t {valid,instr,pc,pcplus4}.
//  Sub-module fetch_skid_buf: 1-entry ifid_t holding register with push/pop/clear/full.
// TESTING
//  1 Reset release, gnt=1, rvalid next cycle: addrs 0,4,8,... one per cycle; ifid_pc_o 0,4,8 consecutive.
//  2 id_stall high 3 cycles mid-stream: IF/ID holds PC 0x8, skid holds 0xC, req low; after release
//    IF/ID shows 0xC then 0x10, no loss or duplicate.
//  3 redirect to 0x100 while 0x14 outstanding: 0x14 response dropped, ifid_valid_o=0 next cycle,
//    0x100 on IF/ID 3 cycles after redirect.
//  4 redirect and id_stall same cycle with skid full: skid cleared, IF/ID=NOP/invalid, fetch resumes at target.
//  5 gnt held low 4 cycles: imem_addr_o stable, pc not incremented; redirect_pc=0x103 -> addr 0x100;
//    pc 0xFFFF_FFFC wraps to 0.
//  6 Assert reset during WAIT: outputs return to reset values immediately; late rvalid ignored.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I fetch types: state encoding, NOP and the IF/ID record
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
  typedef enum logic {IDLE, WAIT} fetch_state_e;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } ifid_t;
  localparam ifid_t IFID_RESET = '{valid: 1'b0, instr: RV_NOP, pc: '0, pcplus4: '0};
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry IF/ID holding register absorbing a response while decode stalls
module fetch_skid_buf
  import rv32_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  logic  clear,
  input  ifid_t d,
  output ifid_t q,
  output logic  full
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q    <= IFID_RESET;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      q    <= d;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with req/gnt/rvalid imem, skid buffer and redirect flush.
// Define FETCH_PERF_EN to add perf_fetched_o/perf_killed_o counters.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_killed_o,
`endif
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pcplus4_o
);
  import rv32_pkg::*;
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, inflight_pc;
  logic            kill, kill_nxt, fire, resp, skid_push, skid_pop, skid_full;
  ifid_t           ifid, ifid_nxt, skid_q, resp_e, hole;
  // a response that cannot reach IF/ID this cycle parks in the skid, so no new request may follow it
  always_comb begin
    resp       = imem_rvalid_i && state == WAIT && !kill && !redirect;
    skid_push  = resp && (id_stall ? ifid.valid : skid_full);
    skid_pop   = !redirect && !id_stall && skid_full;
    imem_req_o = !reset && !redirect && !skid_full && !skid_push && (state == IDLE || imem_rvalid_i);
    fire       = imem_req_o && imem_gnt_i;
    state_nxt  = fire ? WAIT : imem_rvalid_i ? IDLE : state;
    kill_nxt   = redirect ? state == WAIT && !imem_rvalid_i : kill && !imem_rvalid_i;
    pc_nxt     = redirect ? redirect_pc & ~XLEN'(3) : fire ? pc + XLEN'(4) : pc;
    resp_e     = '{valid: 1'b1, instr: imem_rdata_i, pc: inflight_pc, pcplus4: inflight_pc + XLEN'(4)};
    hole       = '{valid: 1'b0, instr: RV_NOP, pc: ifid.pc, pcplus4: ifid.pcplus4};
    ifid_nxt   = redirect ? hole : skid_pop ? skid_q : (!id_stall || !ifid.valid) ? (resp ? resp_e : hole) : ifid;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      kill        <= 1'b0;
      ifid        <= IFID_RESET;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inflight_pc <= fire ? pc : inflight_pc;
      kill        <= kill_nxt;
      ifid        <= ifid_nxt;
    end
  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .clear (redirect),
    .d     (resp_e),
    .q     (skid_q),
    .full  (skid_full)
  );
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_fetched_o <= '0;
      perf_killed_o  <= '0;
    end else begin
      perf_fetched_o <= perf_fetched_o + 32'(resp);
      perf_killed_o  <= perf_killed_o + 32'(imem_rvalid_i && state == WAIT && (kill || redirect))
                        + 32'(redirect && ifid.valid) + 32'(redirect && skid_full);
    end
`endif
  assign imem_addr_o    = pc;
  assign ifid_valid_o   = ifid.valid;
  assign ifid_instr_o   = ifid.instr;
  assign ifid_pc_o      = ifid.pc;
  assign ifid_pcplus4_o = ifid.pcplus4;
endmodule
